control_fsm: RTL and testbench

- Parametrised multi-cycle control sequencer for the Hazwell processor; successor to the purely combinational control decode.
- Owns a stage state machine (fetch/decode/execute/memory/writeback) and drives the register enables, register-file write, ALU op and datapath selects each cycle.
- Adds memory wait-state handling on iRdy, a bounded memory timeout, illegal-opcode trapping and a state/stall/error status.

---
 rtl/control_fsm_if.sv | 44 ++++
 rtl/control_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_control_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Control bundle between the Hazwell multi-cycle sequencer and its datapath.
// The sequencer takes the master modport; the datapath side takes slave.
interface control_fsm_if #(
    parameter int OP_W  = 17,
    parameter int ALU_W = 6
);
    logic [OP_W-1:0]  iOP;
    logic             iRdy;
    logic             iBrTaken;

    logic             PC_en;
    logic             PCT_en;
    logic             IR_en;
    logic             MDR_en;
    logic             MAR_en;
    logic             MOR_en;
    logic             RF_Write;
    logic [ALU_W-1:0] ALU_op;
    logic             MAR_Select;
    logic             ALUB_Select;
    logic             PCA_Select;
    logic [1:0]       PC_Select;
    logic [1:0]       C_Select;
    logic [1:0]       AddrC_Select;
    logic             oMemRd;
    logic             oMemWr;
    logic [2:0]       oState;
    logic             oStall;
    logic [1:0]       oErr;

    modport master (
        input  iOP, iRdy, iBrTaken,
        output PC_en, PCT_en, IR_en, MDR_en, MAR_en, MOR_en, RF_Write, ALU_op,
               MAR_Select, ALUB_Select, PCA_Select, PC_Select, C_Select, AddrC_Select,
               oMemRd, oMemWr, oState, oStall, oErr
    );

    modport slave (
        output iOP, iRdy, iBrTaken,
        input  PC_en, PCT_en, IR_en, MDR_en, MAR_en, MOR_en, RF_Write, ALU_op,
               MAR_Select, ALUB_Select, PCA_Select, PC_Select, C_Select, AddrC_Select,
               oMemRd, oMemWr, oState, oStall, oErr
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control sequencer for the Hazwell processor: stage FSM with
// memory wait states, bounded wait timeout and illegal-opcode trapping.
//
// state  | meaning
// FETCH  | read instruction at PC, wait on iRdy, load IR and PC+4
// DECODE | classify opcode, capture PC+4 into PCT
// EXEC   | ALU op, address calc, or PC redirect for control flow
// MEM    | load/store access, wait on iRdy
// WB     | single-cycle register file write
// TRAP   | illegal opcode or wait timeout; frozen until reset
module control_fsm #(
    parameter int OP_W        = 17,
    parameter int ALU_W       = 6,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            iClk,
    input  logic            iRst,
    control_fsm_if.master   bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ALU_R, C_ALU_I, C_LDW, C_STW, C_BR, C_BEQ, C_CALL, C_CALLR, C_JMP
    } cls_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MEM_TIMEOUT);
    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(6'h31);
    localparam logic [ALU_W-1:0] ALU_ADDI = ALU_W'(6'h04);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       err_q, err_d;
    logic [5:0]       op, opx;
    logic             timeout_hit;
    logic             unused_ok;
    cls_t             cls;

    assign op        = bus.iOP[5:0];
    assign opx       = bus.iOP[OP_W-1 -: 6];
    assign unused_ok = ^bus.iOP[OP_W-7:6];

    // Trap on the wait cycle that would bring the count up to the limit.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == CNT_LIM);

    always_comb begin
        cls = C_ILL;
        case (op)
            6'h3A: begin
                case (opx)
                    6'h05, 6'h0D:                      cls = C_JMP;
                    6'h1D:                             cls = C_CALLR;
                    6'h31, 6'h39, 6'h0E, 6'h16, 6'h1E: cls = C_ALU_R;
                    default:                           cls = C_ILL;
                endcase
            end
            6'h04:   cls = C_ALU_I;
            6'h17:   cls = C_LDW;
            6'h15:   cls = C_STW;
            6'h06:   cls = C_BR;
            6'h26:   cls = C_BEQ;
            6'h00:   cls = C_CALL;
            default: cls = C_ILL;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        bus.PC_en        = 1'b0;
        bus.PCT_en       = 1'b0;
        bus.IR_en        = 1'b0;
        bus.MDR_en       = 1'b0;
        bus.MAR_en       = 1'b0;
        bus.MOR_en       = 1'b0;
        bus.RF_Write     = 1'b0;
        bus.ALU_op       = '0;
        bus.MAR_Select   = 1'b0;
        bus.ALUB_Select  = 1'b0;
        bus.PCA_Select   = 1'b0;
        bus.PC_Select    = 2'b00;
        bus.C_Select     = 2'b00;
        bus.AddrC_Select = 2'b00;
        bus.oMemRd       = 1'b0;
        bus.oMemWr       = 1'b0;
        bus.oStall       = 1'b0;
        if (!iRst) begin
            case (state_q)
                S_FETCH: begin
                    bus.MAR_Select = 1'b1;
                    bus.MAR_en     = 1'b1;
                    bus.oMemRd     = 1'b1;
                    if (bus.iRdy) begin
                        bus.IR_en = 1'b1;
                        bus.PC_en = 1'b1;
                        state_d   = S_DECODE;
                    end else begin
                        bus.oStall = 1'b1;
                        cnt_d      = cnt_inc;
                        if (timeout_hit) begin
                            state_d = S_TRAP;
                            err_d   = 2'b10;
                        end
                    end
                end
                S_DECODE: begin
                    bus.PCT_en = 1'b1;
                    if (cls == C_ILL) begin
                        state_d = S_TRAP;
                        err_d   = 2'b01;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_ALU_R: begin
                            bus.ALU_op = ALU_W'(opx);
                            state_d    = S_WB;
                        end
                        C_ALU_I: begin
                            bus.ALU_op      = ALU_ADDI;
                            bus.ALUB_Select = 1'b1;
                            state_d         = S_WB;
                        end
                        C_LDW, C_STW: begin
                            bus.ALU_op      = ALU_ADD;
                            bus.ALUB_Select = 1'b1;
                            bus.MAR_en      = 1'b1;
                            bus.MOR_en      = (cls == C_STW);
                            state_d         = S_MEM;
                        end
                        C_BR, C_BEQ: begin
                            bus.PC_en      = (cls == C_BR) ? 1'b1 : bus.iBrTaken;
                            bus.PCA_Select = 1'b1;
                            state_d        = S_FETCH;
                        end
                        C_CALL: begin
                            bus.PC_en     = 1'b1;
                            bus.PC_Select = 2'b01;
                            state_d       = S_WB;
                        end
                        C_CALLR, C_JMP: begin
                            bus.PC_en     = 1'b1;
                            bus.PC_Select = 2'b10;
                            state_d       = (cls == C_CALLR) ? S_WB : S_FETCH;
                        end
                        default: begin
                            state_d = S_TRAP;
                            err_d   = 2'b01;
                        end
                    endcase
                end
                S_MEM: begin
                    bus.oMemRd = (cls == C_LDW);
                    bus.oMemWr = (cls == C_STW);
                    if (bus.iRdy) begin
                        bus.MDR_en = (cls == C_LDW);
                        state_d    = (cls == C_LDW) ? S_WB : S_FETCH;
                    end else begin
                        bus.oStall = 1'b1;
                        cnt_d      = cnt_inc;
                        if (timeout_hit) begin
                            state_d = S_TRAP;
                            err_d   = 2'b10;
                        end
                    end
                end
                S_WB: begin
                    bus.RF_Write = 1'b1;
                    case (cls)
                        C_ALU_R: bus.AddrC_Select = 2'b01;
                        C_LDW:   bus.C_Select     = 2'b01;
                        C_CALL, C_CALLR: begin
                            bus.C_Select     = 2'b10;
                            bus.AddrC_Select = 2'b10;
                        end
                        default: ;
                    endcase
                    state_d = S_FETCH;
                end
                S_TRAP: ;
                default: state_d = S_FETCH;
            endcase
            if (state_d != state_q) cnt_d = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.oState = state_q;
    assign bus.oErr   = err_q;
endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-cycle comparison of every output against an
// instruction-level trace model, with directed and randomized instruction mixes.
module tb_control_fsm;
    localparam int OP_W = 17;
    localparam int ALU_W = 6;
    localparam int TO = 4;

    localparam int K_ILL = 0, K_ALU_R = 1, K_ADDI = 2, K_LDW = 3, K_STW = 4;
    localparam int K_BR = 5, K_BEQ = 6, K_CALL = 7, K_CALLR = 8, K_JMP = 9;

    logic iClk = 1'b0;
    logic iRst;

    control_fsm_if #(.OP_W(OP_W), .ALU_W(ALU_W)) bus();
    control_fsm #(.OP_W(OP_W), .ALU_W(ALU_W), .MEM_TIMEOUT(TO)) dut (
        .iClk(iClk), .iRst(iRst), .bus(bus)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic       pc_en, pct_en, ir_en, mdr_en, mar_en, mor_en, rf_write;
        logic [5:0] alu_op;
        logic       mar_sel, alub_sel, pca_sel;
        logic [1:0] pc_sel, c_sel, addrc_sel;
        logic       mem_rd, mem_wr;
        logic [2:0] state;
        logic       stall;
        logic [1:0] err;
    } outs_t;

    typedef struct {
        logic  rdy;
        logic  br;
        outs_t exp;
    } step_t;

    int    n_pass = 0;
    int    n_total = 0;
    step_t trace[$];
    outs_t obs;

    function automatic outs_t observe();
        outs_t o;
        o.pc_en = bus.PC_en;        o.pct_en = bus.PCT_en;      o.ir_en = bus.IR_en;
        o.mdr_en = bus.MDR_en;      o.mar_en = bus.MAR_en;      o.mor_en = bus.MOR_en;
        o.rf_write = bus.RF_Write;  o.alu_op = bus.ALU_op;      o.mar_sel = bus.MAR_Select;
        o.alub_sel = bus.ALUB_Select; o.pca_sel = bus.PCA_Select; o.pc_sel = bus.PC_Select;
        o.c_sel = bus.C_Select;     o.addrc_sel = bus.AddrC_Select;
        o.mem_rd = bus.oMemRd;      o.mem_wr = bus.oMemWr;      o.state = bus.oState;
        o.stall = bus.oStall;       o.err = bus.oErr;
        return o;
    endfunction

    function automatic int kind(input logic [5:0] op, input logic [5:0] opx);
        if (op == 6'h3A) begin
            if (opx == 6'h05 || opx == 6'h0D) return K_JMP;
            if (opx == 6'h1D) return K_CALLR;
            if (opx inside {6'h31, 6'h39, 6'h0E, 6'h16, 6'h1E}) return K_ALU_R;
            return K_ILL;
        end
        case (op)
            6'h04:   return K_ADDI;
            6'h17:   return K_LDW;
            6'h15:   return K_STW;
            6'h06:   return K_BR;
            6'h26:   return K_BEQ;
            6'h00:   return K_CALL;
            default: return K_ILL;
        endcase
    endfunction

    // Expected cycle-by-cycle trace of one instruction: fw fetch waits, mw memory waits.
    function automatic void build(input logic [5:0] op, input logic [5:0] opx, input logic br,
                                  input int fw, input int mw);
        step_t s;
        int k = kind(op, opx);
        trace.delete();
        s.br = br;
        for (int i = 0; i <= fw; i++) begin
            s.exp = '0; s.exp.state = 3'd0;
            s.exp.mar_sel = 1'b1; s.exp.mar_en = 1'b1; s.exp.mem_rd = 1'b1;
            s.rdy = (i == fw);
            if (s.rdy) begin s.exp.ir_en = 1'b1; s.exp.pc_en = 1'b1; end
            else s.exp.stall = 1'b1;
            trace.push_back(s);
        end
        s.exp = '0; s.exp.state = 3'd1; s.exp.pct_en = 1'b1; s.rdy = 1'($urandom);
        trace.push_back(s);
        if (k == K_ILL) begin
            for (int i = 0; i < 2; i++) begin
                s.exp = '0; s.exp.state = 3'd7; s.exp.err = 2'b01; s.rdy = 1'($urandom);
                trace.push_back(s);
            end
            return;
        end
        s.exp = '0; s.exp.state = 3'd2; s.rdy = 1'($urandom);
        case (k)
            K_ALU_R: s.exp.alu_op = opx;
            K_ADDI:  begin s.exp.alu_op = 6'h04; s.exp.alub_sel = 1'b1; end
            K_LDW, K_STW: begin
                s.exp.alu_op = 6'h31; s.exp.alub_sel = 1'b1; s.exp.mar_en = 1'b1;
                s.exp.mor_en = (k == K_STW);
            end
            K_BR:    begin s.exp.pc_en = 1'b1; s.exp.pca_sel = 1'b1; end
            K_BEQ:   begin s.exp.pc_en = br; s.exp.pca_sel = 1'b1; end
            K_CALL:  begin s.exp.pc_en = 1'b1; s.exp.pc_sel = 2'b01; end
            default: begin s.exp.pc_en = 1'b1; s.exp.pc_sel = 2'b10; end
        endcase
        trace.push_back(s);
        if (k == K_LDW || k == K_STW) begin
            for (int i = 0; i <= mw; i++) begin
                s.exp = '0; s.exp.state = 3'd3;
                s.exp.mem_rd = (k == K_LDW); s.exp.mem_wr = (k == K_STW);
                s.rdy = (i == mw);
                if (s.rdy) s.exp.mdr_en = (k == K_LDW); else s.exp.stall = 1'b1;
                trace.push_back(s);
            end
        end
        if (k inside {K_ALU_R, K_ADDI, K_LDW, K_CALL, K_CALLR}) begin
            s.exp = '0; s.exp.state = 3'd4; s.exp.rf_write = 1'b1; s.rdy = 1'($urandom);
            if (k == K_ALU_R) s.exp.addrc_sel = 2'b01;
            if (k == K_LDW) s.exp.c_sel = 2'b01;
            if (k == K_CALL || k == K_CALLR) begin s.exp.c_sel = 2'b10; s.exp.addrc_sel = 2'b10; end
            trace.push_back(s);
        end
    endfunction

    task automatic apply_reset(input string name);
        bus.iRdy = 1'($urandom); bus.iBrTaken = 1'($urandom); iRst = 1'b1;
        @(negedge iClk);
        obs = observe(); obs.state = '0; obs.err = '0;
        n_total++;
        if (obs !== outs_t'(0)) $display("FAIL %s reset_cycle: got %h expected 0", name, obs);
        else n_pass++;
        @(posedge iClk); #1;
        iRst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset("reset");
        bus.iOP = {6'h00, 5'h00, 6'h04};
        build(6'h04, 6'h00, 1'b0, 1, 0);
        foreach (trace[i]) begin
            bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs !== trace[i].exp) $display("FAIL reset_then_addi step %0d: got %h expected %h", i, obs, trace[i].exp);
            else n_pass++;
            @(posedge iClk); #1;
        end
    endtask

    task automatic test_alu_r();
        bus.iOP = {6'h31, 5'($urandom), 6'h3A};
        build(6'h3A, 6'h31, 1'b0, 0, 0);
        foreach (trace[i]) begin
            bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs !== trace[i].exp) $display("FAIL alu_r_add step %0d: got %h expected %h", i, obs, trace[i].exp);
            else n_pass++;
            @(posedge iClk); #1;
        end
    endtask

    task automatic test_ldw_wait();
        bus.iOP = {6'h00, 5'($urandom), 6'h17};
        build(6'h17, 6'h00, 1'b0, 0, 3);
        foreach (trace[i]) begin
            bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs !== trace[i].exp) $display("FAIL ldw_wait step %0d: got %h expected %h", i, obs, trace[i].exp);
            else n_pass++;
            @(posedge iClk); #1;
        end
    endtask

    task automatic test_beq();
        for (int t = 0; t < 2; t++) begin
            bus.iOP = {6'($urandom), 5'($urandom), 6'h26};
            build(6'h26, 6'h00, 1'(t), 0, 0);
            foreach (trace[i]) begin
                bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
                @(negedge iClk); obs = observe(); n_total++;
                if (obs !== trace[i].exp) $display("FAIL beq_taken%0d step %0d: got %h expected %h", t, i, obs, trace[i].exp);
                else n_pass++;
                @(posedge iClk); #1;
            end
        end
    endtask

    task automatic test_call();
        for (int t = 0; t < 2; t++) begin
            bus.iOP = (t == 0) ? {6'($urandom), 5'($urandom), 6'h00} : {6'h1D, 5'($urandom), 6'h3A};
            if (t == 0) build(6'h00, bus.iOP[16:11], 1'b0, 0, 0);
            else        build(6'h3A, 6'h1D, 1'b0, 0, 0);
            foreach (trace[i]) begin
                bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
                @(negedge iClk); obs = observe(); n_total++;
                if (obs !== trace[i].exp) $display("FAIL call%0d step %0d: got %h expected %h", t, i, obs, trace[i].exp);
                else n_pass++;
                @(posedge iClk); #1;
            end
        end
    endtask

    task automatic test_illegal();
        for (int t = 0; t < 2; t++) begin
            bus.iOP = (t == 0) ? {6'($urandom), 5'($urandom), 6'h3F} : {6'h00, 5'($urandom), 6'h3A};
            build(bus.iOP[5:0], bus.iOP[16:11], 1'b0, 0, 0);
            foreach (trace[i]) begin
                bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
                @(negedge iClk); obs = observe(); n_total++;
                if (obs !== trace[i].exp) $display("FAIL illegal%0d step %0d: got %h expected %h", t, i, obs, trace[i].exp);
                else n_pass++;
                @(posedge iClk); #1;
            end
            apply_reset("illegal_recover");
            bus.iRdy = 1'b0;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs.state !== 3'd0 || obs.err !== 2'b00)
                $display("FAIL illegal_recover: got state %0d err %b expected state 0 err 00", obs.state, obs.err);
            else n_pass++;
            @(posedge iClk); #1;
            apply_reset("illegal_recover2");
        end
    endtask

    task automatic test_reset_mid();
        bus.iOP = {6'h39, 5'($urandom), 6'h3A};
        build(6'h3A, 6'h39, 1'b0, 0, 0);
        void'(trace.pop_back());
        foreach (trace[i]) begin
            bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs !== trace[i].exp) $display("FAIL reset_mid step %0d: got %h expected %h", i, obs, trace[i].exp);
            else n_pass++;
            @(posedge iClk); #1;
        end
        apply_reset("reset_in_wb");
    endtask

    task automatic test_timeout();
        step_t s;
        // Fetch stalls for the full limit.
        bus.iOP = {6'h00, 5'h00, 6'h04};
        trace.delete();
        s.br = 1'b0;
        for (int i = 0; i < TO; i++) begin
            s.exp = '0; s.exp.state = 3'd0; s.exp.mar_sel = 1'b1; s.exp.mar_en = 1'b1;
            s.exp.mem_rd = 1'b1; s.exp.stall = 1'b1; s.rdy = 1'b0;
            trace.push_back(s);
        end
        for (int i = 0; i < 2; i++) begin
            s.exp = '0; s.exp.state = 3'd7; s.exp.err = 2'b10; s.rdy = 1'($urandom);
            trace.push_back(s);
        end
        foreach (trace[i]) begin
            bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs !== trace[i].exp) $display("FAIL fetch_timeout step %0d: got %h expected %h", i, obs, trace[i].exp);
            else n_pass++;
            @(posedge iClk); #1;
        end
        apply_reset("timeout_recover");
        // Ready arriving on the limit cycle wins.
        build(6'h04, 6'h00, 1'b0, TO - 1, 0);
        foreach (trace[i]) begin
            bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs !== trace[i].exp) $display("FAIL fetch_limit_ready step %0d: got %h expected %h", i, obs, trace[i].exp);
            else n_pass++;
            @(posedge iClk); #1;
        end
        // Load stalls in MEM for the full limit.
        bus.iOP = {6'h00, 5'h00, 6'h17};
        build(6'h17, 6'h00, 1'b0, 0, 0);
        void'(trace.pop_back());
        void'(trace.pop_back());
        for (int i = 0; i < TO; i++) begin
            s.exp = '0; s.exp.state = 3'd3; s.exp.mem_rd = 1'b1; s.exp.stall = 1'b1; s.rdy = 1'b0;
            trace.push_back(s);
        end
        s.exp = '0; s.exp.state = 3'd7; s.exp.err = 2'b10; s.rdy = 1'b1;
        trace.push_back(s);
        foreach (trace[i]) begin
            bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
            @(negedge iClk); obs = observe(); n_total++;
            if (obs !== trace[i].exp) $display("FAIL mem_timeout step %0d: got %h expected %h", i, obs, trace[i].exp);
            else n_pass++;
            @(posedge iClk); #1;
        end
        apply_reset("mem_timeout_recover");
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] opxs [8];
        logic [5:0] op, opx;
        ops  = '{6'h3A, 6'h04, 6'h17, 6'h15, 6'h06, 6'h26, 6'h00};
        opxs = '{6'h05, 6'h0D, 6'h1D, 6'h31, 6'h39, 6'h0E, 6'h16, 6'h1E};
        for (int n = 0; n < 40; n++) begin
            op  = ops[$urandom_range(0, 6)];
            opx = (op == 6'h3A) ? opxs[$urandom_range(0, 7)] : 6'($urandom);
            bus.iOP = {opx, 5'($urandom), op};
            build(op, opx, 1'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
            foreach (trace[i]) begin
                bus.iRdy = trace[i].rdy; bus.iBrTaken = trace[i].br;
                @(negedge iClk); obs = observe(); n_total++;
                if (obs !== trace[i].exp)
                    $display("FAIL random op=%h opx=%h step %0d: got %h expected %h", op, opx, i, obs, trace[i].exp);
                else n_pass++;
                @(posedge iClk); #1;
            end
        end
    endtask

    initial begin
        iRst = 1'b1;
        bus.iOP = '0;
        bus.iRdy = 1'b0;
        bus.iBrTaken = 1'b0;
        @(posedge iClk); #1;
        test_reset();
        test_alu_r();
        test_ldw_wait();
        test_beq();
        test_call();
        test_reset_mid();
        test_illegal();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
